// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state encoding and response error codes for the bus initiator
package bus_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_RESP} state_t;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
endpackage

// File: rtl/bus_wdog.sv
// bus_wdog: saturating timeout counter (clr/en in, expired out when count reaches TIMEOUT-1)
module bus_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (en && !expired) ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/bus_initiator.sv
// bus_initiator: one-outstanding core-to-bus initiator; req_* from core, bus_* to fabric, resp_* back to core
module bus_initiator
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        bus_en,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_busy,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  state_t      state;
  logic        expired;
  logic        done;
  logic [1:0]  err_nxt;
  logic [31:0] rdata_nxt;
  bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == S_ADDR),
    .en     (state == S_WAIT),
    .expired(expired)
  );
  always_comb begin
    done      = (state == S_ADDR && (!bus_busy || bus_ack)) || (state == S_WAIT && (bus_ack || expired));
    err_nxt   = (state == S_ADDR && !bus_busy) ? ERR_DECODE : bus_ack ? ERR_OK : ERR_TIMEOUT;
    rdata_nxt = (err_nxt == ERR_OK && !bus_we) ? bus_rdata : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      bus_en     <= 1'b0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          state     <= S_ADDR;
          req_ready <= 1'b0;
          bus_en    <= 1'b1;
          bus_addr  <= req_addr;
          bus_we    <= req_we;
          bus_wdata <= req_wdata;
          bus_wstrb <= req_wstrb;
        end
        S_ADDR, S_WAIT: if (done) begin
          state      <= S_RESP;
          bus_en     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= err_nxt;
          resp_rdata <= rdata_nxt;
        end else state <= S_WAIT;
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: table-driven, directed and random checks of bus_initiator against a transaction model
module tb_bus_initiator;
  localparam int TIMEOUT = 16;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        bus_en, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_busy, bus_ack;
  logic [31:0] bus_rdata;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mapped;
    int          ack_at;
    logic [31:0] rd;
    logic [1:0]  err;
    int          en;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[7];
  bus_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_en(bus_en), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // ack_at counts bus_en cycles: 1 is the address cycle, k>1 is the (k-1)th wait cycle, 0 means never
  task automatic model(input logic we, input logic mapped, input int ack_at, input logic [31:0] rd,
                       output logic [1:0] err, output int en, output logic [31:0] rdata);
    if (!mapped) begin
      err = 2'b01;
      en  = 1;
    end else if (ack_at >= 1 && ack_at <= TIMEOUT + 1) begin
      err = 2'b00;
      en  = ack_at;
    end else begin
      err = 2'b10;
      en  = TIMEOUT + 1;
    end
    rdata = (err == 2'b00 && !we) ? rd : 32'h0;
  endtask
  // starts and ends 1 time unit after a rising edge with the DUT idle
  task automatic run_txn(input vec_t v);
    int en_cnt = 0;
    int rc = 0;
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb; req_valid = 1'b1;
    check("req_ready_idle", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_we = ~v.we; req_wstrb = ~v.wstrb;
    check("bus_addr", bus_addr, v.addr);
    check("bus_we", {31'b0, bus_we}, {31'b0, v.we});
    check("bus_wdata", bus_wdata, v.wdata);
    check("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, v.wstrb});
    for (int k = 1; k <= 40 && rc == 0; k++) begin
      bus_busy  = v.mapped;
      bus_ack   = (k == v.ack_at);
      bus_rdata = bus_ack ? v.rd : $urandom;
      en_cnt += int'(bus_en);
      if (resp_valid) begin
        rc = k;
        check("resp_err", {30'b0, resp_err}, {30'b0, v.err});
        check("resp_rdata", resp_rdata, v.rdata);
      end
      @(posedge clk); #1;
    end
    bus_ack = 1'b0; bus_busy = 1'b0;
    check("resp_cycle", rc, v.en + 1);
    check("bus_en_cycles", en_cnt, v.en);
    check("resp_one_pulse", {31'b0, resp_valid}, 0);
    check("ready_after", {31'b0, req_ready}, 1);
    check("bus_addr_hold", bus_addr, v.addr);
  endtask
  initial begin
    vec_t v;
    int n_acc, n_resp, n_overlap;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    bus_busy = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    vt[0] = '{1'b0, 32'h1000_0004, 32'h0,         4'hF, 1'b1, 1,  32'hDEAD_BEEF, 2'b00, 1,  32'hDEAD_BEEF};
    vt[1] = '{1'b1, 32'h1000_0040, 32'hCAFE_F00D, 4'h3, 1'b1, 6,  32'h5555_AAAA, 2'b00, 6,  32'h0};
    vt[2] = '{1'b0, 32'hF000_0000, 32'h0,         4'hF, 1'b0, 0,  32'h1111_2222, 2'b01, 1,  32'h0};
    vt[3] = '{1'b0, 32'h2000_0000, 32'h0,         4'hF, 1'b1, 0,  32'h3333_4444, 2'b10, 17, 32'h0};
    vt[4] = '{1'b0, 32'h2000_0010, 32'h0,         4'hF, 1'b1, 17, 32'h1234_5678, 2'b00, 17, 32'h1234_5678};
    vt[5] = '{1'b0, 32'h2000_0020, 32'h0,         4'hF, 1'b1, 18, 32'h9999_8888, 2'b10, 17, 32'h0};
    vt[6] = '{1'b0, 32'hF000_0100, 32'h0,         4'hF, 1'b0, 1,  32'h7777_6666, 2'b01, 1,  32'h0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_en", {31'b0, bus_en}, 0);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_wstrb", {28'b0, bus_wstrb}, 0);
    check("rst_bus_we", {31'b0, bus_we}, 0);
    check("rst_resp_err", {30'b0, resp_err}, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    for (int i = 0; i < 7; i++) run_txn(vt[i]);
    // asynchronous reset in the middle of a wait phase
    req_we = 1'b0; req_addr = 32'h3000_0000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_busy = 1'b1; bus_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("wait_bus_en", {31'b0, bus_en}, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bus_en", {31'b0, bus_en}, 0);
    check("async_rst_resp_valid", {31'b0, resp_valid}, 0);
    @(negedge clk); rst = 1'b0;
    n_resp = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      n_resp += int'(resp_valid);
    end
    bus_busy = 1'b0;
    check("no_resp_after_rst", n_resp, 0);
    run_txn(vt[0]);
    // req_valid held: every transaction spends one cycle each in idle, address and response
    n_acc = 0; n_resp = 0; n_overlap = 0;
    req_we = 1'b0; req_addr = 32'h1000_0008; req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus_busy = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hA5A5_0000 + k;
      n_acc  += int'(req_ready);
      n_resp += int'(resp_valid);
      n_overlap += int'(resp_valid && (req_ready || bus_en));
      @(posedge clk); #1;
    end
    req_valid = 1'b0; bus_ack = 1'b0; bus_busy = 1'b0;
    check("held_accepts", n_acc, 4);
    check("held_resps", n_resp, 4);
    check("held_overlap", n_overlap, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.addr = $urandom; v.wdata = $urandom; v.wstrb = 4'($urandom_range(0, 15));
      v.mapped = ($urandom_range(0, 3) != 0);
      v.ack_at = $urandom_range(0, 20);
      v.rd = $urandom;
      model(v.we, v.mapped, v.ack_at, v.rd, v.err, v.en, v.rdata);
      run_txn(v);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
